instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Instruction queue between fetch_unit and decode/dispatch in the out-of-order LC-3b core.
- Captures each fetched instruction together with its PC and its BTB hit/prediction bits into a circular FIFO.
- Presents the oldest entry to decode first-word-fall-through, with a valid/accept handshake.
- Drives the back-pressure stall to fetch and empties instantly on a branch-mispredict flush.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  mispredict/exception flush; discards all entries.
- enq  input  1  fetch has a new instruction this cycle; pulsed with fetch's IR/PC load.
- enq_ir  input  16 (lc3b_word)  fetched instruction word.
- enq_pc  input  16 (lc3b_word)  PC of the fetched instruction.
- enq_hit  input  1  BTB hit for this instruction.
- enq_predict  input  1  BTB taken prediction.
- full  output  1  queue full; wired to fetch stall.
- deq  input  1  decode accepts the head entry this cycle.
- deq_valid  output  1  head entry valid (queue not empty).
- deq_ir  output  16  head instruction word.
- deq_pc  output  16  head PC.
- deq_hit  output  1  head BTB hit.
- deq_predict  output  1  head prediction.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - rd_ptr, wr_ptr, count to 0;
  - all storage entries to 0;
  - hence deq_valid=0, full=0, deq_* = 0.
- Reset takes effect mid-operation without waiting for a clock edge. Deassertion is sampled on the next rising edge.
- Storage: DEPTH entries of {ir, pc, hit, predict}. Pointers wrap modulo DEPTH; wrap is natural PTR_W-bit overflow.
- Accepted enqueue: enq=1 and full=0.
  - Write entry at wr_ptr; wr_ptr+1 at the clock edge.
  - Enqueue while full is dropped silently: no state change, no overwrite. Fetch must hold via stall.
  - Simultaneous enq and deq while full: enq still dropped, deq proceeds. full deasserts the following cycle.
- Accepted dequeue: deq=1 and deq_valid=1.
  - rd_ptr+1 at the clock edge.
  - deq while empty is ignored.
- count update:
  - +1 on enqueue only;
  - -1 on dequeue only;
  - unchanged when both are accepted or neither is.
- Simultaneous enq and deq while empty: enq accepted, deq ignored, count becomes 1.
- full = (count == DEPTH); deq_valid = (count != 0). Both are combinational from registered count, with no input-to-output path.
- deq_* are combinational reads of the head entry (first-word fall-through). Zero-latency view of the head; an enqueued instruction is visible on deq_* one cycle after its enq edge.
- Latency: enq at edge N gives deq_valid=1 during cycle N+1 when the queue was empty.
- flush=1 at a clock edge:
  - rd_ptr, wr_ptr, count become 0;
  - overrides enq and deq in the same cycle, so the flushing cycle's enq is discarded;
  - storage contents are not cleared, but are unobservable because deq_valid=0.
- After flush, full=0 next cycle, so fetch resumes from the redirected PC.
- No combinational path from enq to full or from deq to deq_valid.

Decomposition:
- lc3b_types gains:
  - struct lc3b_iq_entry {lc3b_word ir; lc3b_word pc; logic hit; logic predict;};
  - localparam IQ_DEPTH = 8, used by the core top level.
- lc3b_word is reused for all 16-bit fields.
- Single module, no sub-module: the storage array and pointer logic are small enough to keep inline, and no generic FIFO exists that carries a flush.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, release → deq_valid=0, full=0, count=0, deq_ir=0x0000.
- Single pass: enq ir=0x1261 pc=0x0010 hit=1 predict=0 → next cycle deq_valid=1 with the same fields, count=1. Then deq=1 → count=0, deq_valid=0.
- Fill and order:
  - enq 8 words 0xA000..0xA007 with no deq → full=1, count=8.
  - A 9th enq (0xBEEF) is dropped.
  - Dequeue 8 → words read out 0xA000..0xA007 in order, 0xBEEF never appears.
- Simultaneous and wrap-around:
  - With count=3, run enq+deq every cycle for 12 cycles (pointers wrap) → count stays 3 and output order is preserved.
  - With count=8, enq+deq together → count=7, enq dropped.
- Flush: with count=5, assert flush together with enq=1 → next cycle count=0, deq_valid=0, full=0. A subsequent enq 0x5020 is the first word out.
- Asynchronous reset mid-stream: with count=4, pull rst_n low between clock edges → count=0 and deq_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b core types: machine word, instruction-queue entry and
// the queue depth used by the core top level.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word ir;
        lc3b_word pc;
        logic     hit;
        logic     predict;
    } lc3b_iq_entry;

    localparam int IQ_DEPTH = 8;

endpackage

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode/dispatch, with
// first-word-fall-through head, fetch stall and single-cycle flush.
module instr_queue
    import lc3b_types::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enq,
    input  lc3b_word         enq_ir,
    input  lc3b_word         enq_pc,
    input  logic             enq_hit,
    input  logic             enq_predict,
    output logic             full,
    input  logic             deq,
    output logic             deq_valid,
    output lc3b_word         deq_ir,
    output lc3b_word         deq_pc,
    output logic             deq_hit,
    output logic             deq_predict,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    lc3b_iq_entry mem_q [DEPTH];
    lc3b_iq_entry mem_d [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic         do_enq;
    logic         do_deq;
    lc3b_iq_entry head;

    assign full      = (count_q == CNT_FULL);
    assign deq_valid = (count_q != '0);
    assign count     = count_q;

    assign do_enq = enq && !full;
    assign do_deq = deq && deq_valid;

    assign head        = mem_q[rd_ptr_q];
    assign deq_ir      = head.ir;
    assign deq_pc      = head.pc;
    assign deq_hit     = head.hit;
    assign deq_predict = head.predict;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // flush leaves storage untouched; empty pointers hide it
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) begin
                mem_d[wr_ptr_q] = '{ir: enq_ir, pc: enq_pc,
                                    hit: enq_hit, predict: enq_predict};
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({do_enq, do_deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_instr_queue;
    import lc3b_types::*;

    localparam int DEPTH = 8;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     flush = 1'b0;
    logic     enq = 1'b0;
    lc3b_word enq_ir = '0;
    lc3b_word enq_pc = '0;
    logic     enq_hit = 1'b0;
    logic     enq_predict = 1'b0;
    logic     deq = 1'b0;
    logic     full;
    logic     deq_valid;
    lc3b_word deq_ir;
    lc3b_word deq_pc;
    logic     deq_hit;
    logic     deq_predict;
    logic [3:0] count;

    int total = 0;
    int bad = 0;

    logic [33:0] mq[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq(enq), .enq_ir(enq_ir), .enq_pc(enq_pc),
        .enq_hit(enq_hit), .enq_predict(enq_predict),
        .full(full), .deq(deq), .deq_valid(deq_valid),
        .deq_ir(deq_ir), .deq_pc(deq_pc), .deq_hit(deq_hit),
        .deq_predict(deq_predict), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("count", 64'(count), 64'(mq.size()));
        chk("valid", 64'(deq_valid), 64'(mq.size() != 0));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        if (mq.size() != 0)
            chk("head", 64'({deq_ir, deq_pc, deq_hit, deq_predict}),
                64'(mq[0]));
    endtask

    task automatic step(input logic e, input lc3b_word ir,
                        input lc3b_word pc, input logic h,
                        input logic p, input logic d, input logic f);
        @(negedge clk);
        check_model();
        enq = e; enq_ir = ir; enq_pc = pc;
        enq_hit = h; enq_predict = p;
        deq = d; flush = f;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            bit de;
            bit ee;
            de = d && (mq.size() != 0);
            ee = e && (mq.size() != DEPTH);
            if (de) void'(mq.pop_front());
            if (ee) mq.push_back({ir, pc, h, p});
        end
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(deq_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ir", 64'(deq_ir), 64'h0);
        rst_n = 1'b1;
        idle();

        // single pass
        step(1'b1, 16'h1261, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sp_valid", 64'(deq_valid), 64'd1);
        chk("sp_ir", 64'(deq_ir), 64'h1261);
        chk("sp_pc", 64'(deq_pc), 64'h0010);
        chk("sp_hit", 64'({deq_hit, deq_predict}), 64'b10);
        chk("sp_count", 64'(count), 64'd1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("sp_empty", 64'({deq_valid, count}), 64'd0);

        // fill, overflow drop, ordered drain
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'hA000 + 16'(i), 16'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd8);
        step(1'b1, 16'hBEEF, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_ir", 64'(deq_ir), 64'(16'hA000 + 16'(i)));
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        #1;
        chk("drain_empty", 64'(deq_valid), 64'd0);

        // steady enq+deq with pointer wrap
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'hC000 + 16'(i), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b1, 16'hC100 + 16'(i), 16'(i), 1'(i), 1'b0, 1'b1, 1'b0);
        #1;
        chk("wrap_count", 64'(count), 64'd3);
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'hD000 + 16'(i), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("full_ed_count", 64'(count), 64'd7);

        // flush with simultaneous enq
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("pre_flush", 64'(count), 64'd5);
        step(1'b1, 16'h7777, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_flags", 64'({deq_valid, full}), 64'd0);
        step(1'b1, 16'h5020, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_flush_ir", 64'(deq_ir), 64'h5020);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'hE000 + 16'(i), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst", 64'(count), 64'd4);
        enq = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(deq_valid), 64'd0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0));
        end
        idle();
        @(negedge clk);
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
